ysyx_24070016_data_sram: RTL and testbench

Memory-side responder for the core's load/store path: accepts one read or write request at a time over a valid/ready request channel and returns one response per request over a valid/ready response channel. It sits behind the LSU in place of the direct DPI data-memory call. It holds a word-addressed on-chip array, applies size-derived byte strobes, and returns right-aligned, zero-filled read data; sign extension stays in the initiator. Response latency is fixed or pseudo-random, so the initiator must tolerate wait states.

---
 rtl/ysyx_24070016_mem_pkg.sv | 29 ++
 rtl/ysyx_24070016_lfsr8.sv | 29 ++
 rtl/ysyx_24070016_data_sram.sv | 193 +++++++++++++++++++
 tb/tb_ysyx_24070016_data_sram.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_24070016_mem_pkg.sv
// Shared definitions for the data-side memory responder.
// Holds the request size encodings, the responder FSM state type, the LFSR seed,
// and a helper that turns (size, byte lane) into a 4-bit write strobe.
package ysyx_24070016_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_e;

  localparam logic [7:0] LFSR_SEED = 8'hA5;

  // Misaligned and illegal sizes never reach the array, so lane overflow is not a concern here.
  function automatic logic [3:0] size_strobe(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] strb;
    case (size)
      SZ_BYTE: strb = 4'b0001 << lane;
      SZ_HALF: strb = 4'b0011 << lane;
      default: strb = 4'b1111;
    endcase
    return strb;
  endfunction

endpackage

// File: rtl/ysyx_24070016_lfsr8.sv
// 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1, advancing every cycle.
// Used to draw per-request response latency when YSYX_24070016_SRAM_RAND_LAT_EN is defined.
// Ports:
//   clk - rising-edge clock
//   rst - synchronous active-high reset, loads LFSR_SEED
//   out - current LFSR state
module ysyx_24070016_lfsr8
  import ysyx_24070016_mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] out
);

  logic [7:0] lfsr_q;
  logic       fb;

  assign fb  = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
  assign out = lfsr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= {lfsr_q[6:0], fb};
    end
  end

endmodule

// File: rtl/ysyx_24070016_data_sram.sv
// Data-side memory responder for the LSU: one outstanding read or write at a time over
// valid/ready request and response channels, backed by a word-addressed on-chip array.
// Write data is right-aligned and placed by byte strobes; read data returns right-aligned
// and zero-filled (sign extension is left to the initiator).
// Optional feature macro: YSYX_24070016_SRAM_RAND_LAT_EN selects a pseudo-random latency
// of 1..8 cycles per request instead of the fixed LATENCY parameter.
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   req_valid/req_ready       - request handshake
//   req_wren, req_size        - 1 = write; size 0 byte, 1 half, 2 word
//   req_addr, req_wdata       - byte address, right-aligned write data
//   rsp_valid/rsp_ready       - response handshake
//   rsp_rdata, rsp_err        - read data (0 for writes/errors), access fault
module ysyx_24070016_data_sram
  import ysyx_24070016_mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned LATENCY     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wren,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned IdxW      = $clog2(DEPTH_WORDS);
  localparam int unsigned CntW      = $clog2(LATENCY + 8);
  localparam logic [31:0] SpanBytes = 32'(DEPTH_WORDS) << 2;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d, lat_m1;
  logic            wren_q;
  logic [1:0]      size_q;
  logic [31:0]     addr_q, wdata_q;
  logic [31:0]     rdata_q, rdata_d;
  logic            err_q;
  logic [31:0]     mem [DEPTH_WORDS];

  logic            accept, commit;
  logic            op_wren, op_err;
  logic [1:0]      op_size, lane;
  logic [31:0]     op_addr, op_wdata, op_off, wword, rword;
  logic [IdxW-1:0] op_idx;
  logic [3:0]      strb;

`ifdef YSYX_24070016_SRAM_RAND_LAT_EN
  logic [7:0] lfsr;

  ysyx_24070016_lfsr8 u_lfsr (
    .clk (clk),
    .rst (rst),
    .out (lfsr)
  );

  assign lat_m1 = CntW'(lfsr[2:0]);
`else
  assign lat_m1 = CntW'(LATENCY - 1);
`endif

  assign req_ready = (state_q == StIdle) && !rst;
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (state_q == StResp);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  // With a one-cycle latency the commit happens on the accepting edge, before the
  // latch registers hold the request, so take the operands straight off the bus then.
  always_comb begin
    op_wren  = wren_q;
    op_size  = size_q;
    op_addr  = addr_q;
    op_wdata = wdata_q;
    if (state_q == StIdle) begin
      op_wren  = req_wren;
      op_size  = req_size;
      op_addr  = req_addr;
      op_wdata = req_wdata;
    end
  end

  // Addresses below BASE_ADDR wrap to large offsets, so one compare covers both bounds.
  assign op_off = op_addr - BASE_ADDR;
  assign op_idx = op_off[IdxW+1:2];
  assign lane   = op_addr[1:0];
  assign strb   = size_strobe(op_size, lane);
  assign wword  = op_wdata << {lane, 3'b000};
  assign rword  = mem[op_idx] >> {lane, 3'b000};

  always_comb begin
    op_err = 1'b0;
    case (op_size)
      SZ_BYTE: op_err = 1'b0;
      SZ_HALF: op_err = lane[0];
      SZ_WORD: op_err = (lane != 2'd0);
      default: op_err = 1'b1;
    endcase
    if (op_off >= SpanBytes) begin
      op_err = 1'b1;
    end
  end

  always_comb begin
    rdata_d = '0;
    if (!op_wren && !op_err) begin
      case (op_size)
        SZ_BYTE: rdata_d = {24'b0, rword[7:0]};
        SZ_HALF: rdata_d = {16'b0, rword[15:0]};
        default: rdata_d = rword;
      endcase
    end
  end

  // The counter reaches zero on the edge that enters RESP, giving rsp_valid L cycles
  // after the request handshake.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          cnt_d = lat_m1;
          if (lat_m1 == '0) begin
            state_d = StResp;
            commit  = 1'b1;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CntW'(1)) begin
          state_d = StResp;
          commit  = 1'b1;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (commit) begin
        rdata_q <= rdata_d;
        err_q   <= op_err;
      end
    end
  end

  // Request fields are captured at the handshake; the initiator may change them after.
  always_ff @(posedge clk) begin
    if (accept) begin
      wren_q  <= req_wren;
      size_q  <= req_size;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  // Array is never reset; a reset on the commit edge suppresses the write.
  always_ff @(posedge clk) begin
    if (commit && !rst && op_wren && !op_err) begin
      for (int b = 0; b < 4; b++) begin
        if (strb[b]) begin
          mem[op_idx][8*b +: 8] <= wword[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_ysyx_24070016_data_sram.sv
module tb_ysyx_24070016_data_sram;
  import ysyx_24070016_mem_pkg::*;

  localparam int unsigned Lat = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wren = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   last_lat = 0;

  always #5 clk = ~clk;

  ysyx_24070016_data_sram #(
    .BASE_ADDR   (32'h8000_0000),
    .DEPTH_WORDS (4096),
    .LATENCY     (Lat)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wren  (req_wren),
    .req_size  (req_size),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one request, then wait for and score its response. hold > 0 keeps rsp_ready low
  // for that many cycles after rsp_valid rises.
  task automatic txn(input logic wr, input logic [1:0] sz, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] er, input logic ee,
                     input int hold);
    exp_t        e;
    int          w;
    int          n;
    logic [31:0] snap_d;
    logic        snap_e;
    sb.push_back('{rdata: er, err: ee});
    @(negedge clk);
    req_valid = 1'b1;
    req_wren  = wr;
    req_size  = sz;
    req_addr  = a;
    req_wdata = wd;
    rsp_ready = (hold == 0);
    w = 0;
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("req_ready_wait", 32'(w < 20), 32'd1);
    @(posedge clk);
    #1;
    // Scramble the bus after the handshake; the responder must not depend on it.
    req_valid = 1'b0;
    req_wren  = 1'($urandom);
    req_size  = 2'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
    for (n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (rsp_valid) break;
      check("busy_req_ready", 32'(req_ready), 32'd0);
    end
    e = sb.pop_front();
    if (n > 20) begin
      check("rsp_timeout", 32'd0, 32'd1);
      rsp_ready = 1'b1;
      return;
    end
    last_lat = n;
`ifdef YSYX_24070016_SRAM_RAND_LAT_EN
    check("latency_range", 32'(n >= 1 && n <= 8), 32'd1);
`else
    check("latency", 32'(n), 32'(Lat));
`endif
    if (hold > 0) begin
      snap_d = rsp_rdata;
      snap_e = rsp_err;
      for (int k = 0; k < hold; k++) begin
        @(negedge clk);
        check("bp_valid", 32'(rsp_valid), 32'd1);
        check("bp_rdata", rsp_rdata, snap_d);
        check("bp_err", 32'(rsp_err), 32'(snap_e));
        check("bp_req_ready", 32'(req_ready), 32'd0);
      end
      rsp_ready = 1'b1;
    end
    check("rsp_rdata", rsp_rdata, e.rdata);
    check("rsp_err", 32'(rsp_err), 32'(e.err));
    @(posedge clk);
    #1;
    @(negedge clk);
    check("turnaround_ready", 32'(req_ready), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(req_ready), 32'd1);
  endtask

  initial begin
    int valid_seen;
`ifdef YSYX_24070016_SRAM_RAND_LAT_EN
    int seq_a[200];
`endif
    do_reset();

    // Word write/read, then byte write into lane 3 and sub-word reads.
    txn(1'b1, SZ_WORD, 32'h8000_0010, 32'hDEAD_BEEF, 32'h0, 1'b0, 0);
    txn(1'b0, SZ_WORD, 32'h8000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0, 0);
    txn(1'b1, SZ_BYTE, 32'h8000_0013, 32'h0000_005A, 32'h0, 1'b0, 0);
    txn(1'b0, SZ_HALF, 32'h8000_0012, 32'h0, 32'h0000_5AAD, 1'b0, 0);
    txn(1'b0, SZ_WORD, 32'h8000_0010, 32'h0, 32'h5AAD_BEEF, 1'b0, 0);
    txn(1'b0, SZ_BYTE, 32'h8000_0011, 32'h0, 32'h0000_00BE, 1'b0, 0);
    txn(1'b0, SZ_BYTE, 32'h8000_0013, 32'h0, 32'h0000_005A, 1'b0, 0);

    // Faults: misaligned half/word, below base, illegal size, one past the end.
    txn(1'b0, SZ_HALF, 32'h8000_0011, 32'h0, 32'h0, 1'b1, 0);
    txn(1'b1, SZ_WORD, 32'h8000_0012, 32'h1111_1111, 32'h0, 1'b1, 0);
    txn(1'b0, SZ_WORD, 32'h8000_0010, 32'h0, 32'h5AAD_BEEF, 1'b0, 0);
    txn(1'b0, SZ_WORD, 32'h7FFF_FFFC, 32'h0, 32'h0, 1'b1, 0);
    txn(1'b0, 2'd3,    32'h8000_0010, 32'h0, 32'h0, 1'b1, 0);
    txn(1'b1, SZ_WORD, 32'h8000_4000, 32'hFFFF_FFFF, 32'h0, 1'b1, 0);

    // Last word in range, half write ignoring upper data bits, byte at lane 0.
    txn(1'b1, SZ_WORD, 32'h8000_3FFC, 32'h0BAD_F00D, 32'h0, 1'b0, 0);
    txn(1'b0, SZ_WORD, 32'h8000_3FFC, 32'h0, 32'h0BAD_F00D, 1'b0, 0);
    txn(1'b1, SZ_WORD, 32'h8000_0014, 32'h0, 32'h0, 1'b0, 0);
    txn(1'b1, SZ_HALF, 32'h8000_0016, 32'hABCD_1234, 32'h0, 1'b0, 0);
    txn(1'b0, SZ_WORD, 32'h8000_0014, 32'h0, 32'h1234_0000, 1'b0, 0);
    txn(1'b1, SZ_BYTE, 32'h8000_0000, 32'hFFFF_FFA5, 32'h0, 1'b0, 0);
    txn(1'b0, SZ_BYTE, 32'h8000_0000, 32'h0, 32'h0000_00A5, 1'b0, 0);

    // Backpressure on a read response.
    txn(1'b0, SZ_WORD, 32'h8000_0010, 32'h0, 32'h5AAD_BEEF, 1'b0, 5);

`ifndef YSYX_24070016_SRAM_RAND_LAT_EN
    // Reset lands on the commit edge of a pending write: write must be dropped.
    txn(1'b1, SZ_WORD, 32'h8000_0020, 32'hCAFE_F00D, 32'h0, 1'b0, 0);
    @(negedge clk);
    req_valid = 1'b1;
    req_wren  = 1'b1;
    req_size  = SZ_WORD;
    req_addr  = 32'h8000_0020;
    req_wdata = 32'h1234_5678;
    check("rw_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("rw_rst_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    valid_seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid) valid_seen++;
    end
    check("rw_no_rsp", 32'(valid_seen), 32'd0);
    txn(1'b0, SZ_WORD, 32'h8000_0020, 32'h0, 32'hCAFE_F00D, 1'b0, 0);
`else
    // Latency sequence after reset must repeat exactly.
    do_reset();
    for (int i = 0; i < 200; i++) begin
      txn(1'b0, SZ_WORD, 32'h8000_0010, 32'h0, 32'h5AAD_BEEF, 1'b0, 0);
      seq_a[i] = last_lat;
    end
    do_reset();
    for (int i = 0; i < 200; i++) begin
      txn(1'b0, SZ_WORD, 32'h8000_0010, 32'h0, 32'h5AAD_BEEF, 1'b0, 0);
      check("lat_repeat", 32'(last_lat), 32'(seq_a[i]));
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
